// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared encodings for the byte-serial memory controller.
//               Provides the FSM state type, ls_size encodings, the requester
//               owner type, a zero word constant, and a helper that maps
//               ls_size onto a byte count.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Controller state; busy is simply "state != ST_IDLE".
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Which requester owns the transfer in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // ls_size encodings. Encoding 0 is illegal and handled as a byte access.
    localparam logic [1:0] c_size_b = 2'd1;
    localparam logic [1:0] c_size_h = 2'd2;
    localparam logic [1:0] c_size_w = 2'd3;

    localparam logic [31:0] c_zero_word = 32'h0000_0000;

    // Byte count for a load/store of the given size.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            c_size_h: n = 3'd2;
            c_size_w: n = 3'd4;
            default:  n = 3'd1;
        endcase
        return n;
    endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Byte-serial memory controller between the IF/MEM stages and
//               a single 8-bit RAM port. Load/store requests win arbitration
//               over fetches; 1/2/4-byte transfers are serialised one byte
//               per cycle and returned as zero-extended little-endian words
//               with a one-cycle completion pulse.
//
// Ports       : clk, rst             clock / synchronous active-high reset
//               rdy                  global enable, low freezes all state
//               if_req/if_addr       fetch request (always 4 bytes)
//               if_inst/if_pc        fetched word and its address
//               if_success           fetch-complete pulse
//               ls_req/ls_we/ls_addr/ls_size/ls_wdata  load/store request
//               ls_rdata/ls_done     load data and load/store-complete pulse
//               busy                 transfer in flight
//               mem_din/mem_dout/mem_a/mem_wr          RAM byte port
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_inst,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_success,

    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [1:0]            ls_size,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_done,

    output logic                  busy,

    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  r_state;
    owner_t                  r_owner;
    logic [2:0]              r_cnt;      // edges since accept (1..N)
    logic [2:0]              r_n;        // bytes in this transfer
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_buf;      // bytes 0..N-2 collected so far

    logic [ADDR_WIDTH-1:0]   r_mem_a;
    logic [7:0]              r_mem_dout;
    logic                    r_mem_wr;
    logic [DATA_WIDTH-1:0]   r_if_inst;
    logic [ADDR_WIDTH-1:0]   r_if_pc;
    logic                    r_if_success;
    logic [DATA_WIDTH-1:0]   r_ls_rdata;
    logic                    r_ls_done;
    logic                    r_busy;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                    w_req_any;
    logic                    w_sel_ls;
    logic [2:0]              w_req_n;
    logic                    w_last;
    logic [ADDR_WIDTH-1:0]   w_next_a;
    logic [1:0]              w_cap_idx;
    logic [4:0]              w_cap_pos;
    logic [4:0]              w_wr_pos;
    logic [7:0]              w_wr_byte;
    logic [DATA_WIDTH-1:0]   w_word;

    assign w_sel_ls  = ls_req;
    assign w_req_any = ls_req | if_req;
    assign w_req_n   = w_sel_ls ? size_to_bytes(ls_size) : 3'd4;
    assign w_last    = (r_cnt == r_n);
    assign w_next_a  = r_base + ADDR_WIDTH'(r_cnt);

    // mem_din at edge Ek holds the byte addressed at edge E(k-1), i.e.
    // byte k-1. For k = 4 the two-bit wrap gives index 3.
    assign w_cap_idx = r_cnt[1:0] - 2'd1;
    assign w_cap_pos = {w_cap_idx, 3'b000};

    // Store byte k goes out at edge Ek (k < N, so k is 1..3 here).
    assign w_wr_pos  = {r_cnt[1:0], 3'b000};
    assign w_wr_byte = r_wdata[w_wr_pos +: 8];

    // Final word: collected bytes plus the last byte straight off mem_din.
    // Bytes at or above N stay zero because r_buf is cleared on accept.
    always_comb begin
        w_word                = r_buf;
        w_word[w_cap_pos +: 8] = mem_din;
    end

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_cnt        <= 3'd0;
            r_n          <= 3'd0;
            r_base       <= '0;
            r_wdata      <= '0;
            r_buf        <= '0;
            r_mem_a      <= '0;
            r_mem_dout   <= 8'h00;
            r_mem_wr     <= 1'b0;
            r_if_inst    <= '0;
            r_if_pc      <= '0;
            r_if_success <= 1'b0;
            r_ls_rdata   <= '0;
            r_ls_done    <= 1'b0;
            r_busy       <= 1'b0;
        end else if (rdy) begin
            r_if_success <= 1'b0;
            r_ls_done    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_base   <= w_sel_ls ? ls_addr : if_addr;
                        r_n      <= w_req_n;
                        r_owner  <= w_sel_ls ? OWN_LS : OWN_IF;
                        r_wdata  <= ls_wdata;
                        r_buf    <= '0;
                        r_cnt    <= 3'd1;
                        r_mem_a  <= w_sel_ls ? ls_addr : if_addr;
                        r_busy   <= 1'b1;
                        if (w_sel_ls && ls_we) begin
                            r_mem_wr   <= 1'b1;
                            r_mem_dout <= ls_wdata[7:0];
                            r_state    <= ST_WRITE;
                        end else begin
                            r_mem_wr   <= 1'b0;
                            r_state    <= ST_READ;
                        end
                    end else begin
                        r_mem_wr <= 1'b0;
                    end
                end

                ST_READ: begin
                    if (w_last) begin
                        if (r_owner == OWN_IF) begin
                            r_if_inst    <= w_word;
                            r_if_pc      <= r_base;
                            r_if_success <= 1'b1;
                        end else begin
                            r_ls_rdata   <= w_word;
                            r_ls_done    <= 1'b1;
                        end
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_buf[w_cap_pos +: 8] <= mem_din;
                        r_mem_a <= w_next_a;
                        r_cnt   <= r_cnt + 3'd1;
                    end
                end

                ST_WRITE: begin
                    if (w_last) begin
                        r_mem_wr  <= 1'b0;
                        r_ls_done <= 1'b1;
                        r_cnt     <= 3'd0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_mem_a    <= w_next_a;
                        r_mem_dout <= w_wr_byte;
                        r_mem_wr   <= 1'b1;
                        r_cnt      <= r_cnt + 3'd1;
                    end
                end

                default: begin
                    r_mem_wr <= 1'b0;
                    r_cnt    <= 3'd0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_a      = r_mem_a;
    assign mem_dout   = r_mem_dout;
    assign mem_wr     = r_mem_wr;
    assign if_inst    = r_if_inst;
    assign if_pc      = r_if_pc;
    assign if_success = r_if_success;
    assign ls_rdata   = r_ls_rdata;
    assign ls_done    = r_ls_done;
    assign busy       = r_busy;

endmodule : mem_ctrl
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl. A byte-array RAM sits on
//               the memory port (combinational read of mem_a, write on the
//               clock edge while mem_wr is high). A separate reference byte
//               image tracks what memory should hold so that loads, fetches
//               and stores can be predicted as plain little-endian words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_success;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [1:0]  ls_size;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic        busy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int checks;
    int errors;

    mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_success (if_success),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_size    (ls_size),
        .ls_wdata   (ls_wdata),
        .ls_rdata   (ls_rdata),
        .ls_done    (ls_done),
        .busy       (busy),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_a      (mem_a),
        .mem_wr     (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // RAM (64 KiB image, address taken modulo 2^16) and reference image
    // ------------------------------------------------------------------
    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            32'h1000: return 8'h13;
            32'h0030: return 8'h80;
            32'h0031: return 8'h34;
            32'h0032: return 8'h12;
            32'hFFFE: return 8'h11;
            32'hFFFF: return 8'h22;
            32'h0000: return 8'h33;
            32'h0001: return 8'h44;
            default:  return 8'h00;
        endcase
    endfunction

    assign mem_din = ram[mem_a[15:0]];

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        end
    end

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[16'(addr + 32'(i))];
        return v;
    endfunction

    function automatic int nbytes(input bit fetch, input logic [1:0] size);
        if (fetch)        return 4;
        if (size == 2'd3) return 4;
        if (size == 2'd2) return 2;
        return 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transfer. Entered and left at #1 after a rising edge.
    task automatic run_xfer(input bit fetch, input bit we, input logic [31:0] addr,
                            input logic [1:0] size, input logic [31:0] wdata,
                            input logic [31:0] exp, input string tag);
        int          n;
        int          lat;
        bit          got;
        bit          seq_ok;
        logic [31:0] wr_got;
        logic [31:0] mask;
        n = nbytes(fetch, size);
        if (fetch) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            ls_req   = 1'b1;
            ls_we    = we;
            ls_addr  = addr;
            ls_size  = size;
            ls_wdata = wdata;
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        ls_req = 1'b0;
        seq_ok = 1'b1;
        got    = 1'b0;
        lat    = 0;
        while (!got && lat < 20) begin
            if (lat < n && (mem_a !== addr + 32'(lat) || busy !== 1'b1 ||
                            mem_wr !== (!fetch && we)))
                seq_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (if_success || ls_done) got = 1'b1;
        end
        chk($sformatf("%s latency", tag), 32'(lat), 32'(n));
        chk($sformatf("%s addr_seq", tag), 32'(seq_ok), 32'd1);
        if (fetch) begin
            chk($sformatf("%s if_pulse", tag), 32'(if_success && !ls_done), 32'd1);
            chk($sformatf("%s if_inst", tag), if_inst, exp);
            chk($sformatf("%s if_pc", tag), if_pc, addr);
        end else begin
            chk($sformatf("%s ls_pulse", tag), 32'(ls_done && !if_success), 32'd1);
            if (!we) begin
                chk($sformatf("%s ls_rdata", tag), ls_rdata, exp);
            end else begin
                mask   = (n == 4) ? 32'hFFFF_FFFF : (n == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
                wr_got = 32'h0;
                for (int i = 0; i < n; i++) wr_got[8*i +: 8] = ram[16'(addr + 32'(i))];
                chk($sformatf("%s mem_wr_end", tag), 32'(mem_wr), 32'd0);
                chk($sformatf("%s stored", tag), wr_got, wdata & mask);
                for (int i = 0; i < n; i++) ref_mem[16'(addr + 32'(i))] = wdata[8*i +: 8];
            end
        end
        chk($sformatf("%s busy_end", tag), 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("%s pulse_width", tag), {30'd0, if_success, ls_done}, 32'd0);
    endtask

    typedef struct {
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int          e_ls;
        int          e_if;
        int          lat;
        bit          got;
        logic [31:0] r_ls;
        logic [31:0] r_if;
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          kind;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

        //         fetch we  addr           size  wdata          expected
        tbl[0] = '{1'b1, 1'b0, 32'h0000_1000, 2'd3, 32'h0,         32'h0000_0013};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_2002, 2'd3, 32'hAABB_CCDD, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 32'h0000_2002, 2'd3, 32'h0,         32'hAABB_CCDD};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0030, 2'd1, 32'h0,         32'h0000_0080};
        tbl[4] = '{1'b0, 1'b0, 32'h0000_0031, 2'd2, 32'h0,         32'h0000_1234};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_0031, 2'd0, 32'h0,         32'h0000_0034};
        tbl[6] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 2'd3, 32'h0,         32'h4433_2211};
        tbl[7] = '{1'b0, 1'b1, 32'h0000_0040, 2'd2, 32'h1234_BEEF, 32'h0};
        tbl[8] = '{1'b0, 1'b0, 32'h0000_0040, 2'd3, 32'h0,         32'h0000_BEEF};
        tbl[9] = '{1'b1, 1'b0, 32'h0000_2003, 2'd3, 32'h0,         32'h00AA_BBCC};

        rst      = 1'b1;
        rdy      = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_addr  = 32'h0;
        ls_size  = 2'd1;
        ls_wdata = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst mem_a", mem_a, 32'h0);
        chk("rst mem_wr", 32'(mem_wr), 32'd0);
        chk("rst mem_dout", 32'(mem_dout), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst pulses", {30'd0, if_success, ls_done}, 32'd0);
        chk("rst if_inst", if_inst, 32'h0);
        chk("rst if_pc", if_pc, 32'h0);
        chk("rst ls_rdata", ls_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 10; i++)
            run_xfer(tbl[i].fetch, tbl[i].we, tbl[i].addr, tbl[i].size,
                     tbl[i].wdata, tbl[i].exp, $sformatf("vec%0d", i));

        // Simultaneous requests: load goes first, fetch follows after the
        // load's done cycle.
        ls_req  = 1'b1; ls_we = 1'b0; ls_addr = 32'h30; ls_size = 2'd1;
        if_req  = 1'b1; if_addr = 32'h1000;
        e_ls = 0; e_if = 0; r_ls = 32'h0; r_if = 32'h0;
        for (int e = 1; e <= 20 && e_if == 0; e++) begin
            @(posedge clk); #1;
            chk("sim exclusive", 32'(if_success && ls_done), 32'd0);
            if (ls_done) begin
                e_ls   = e;
                r_ls   = ls_rdata;
                ls_req = 1'b0;
            end
            if (if_success) begin
                e_if   = e;
                r_if   = if_inst;
                if_req = 1'b0;
            end
        end
        ls_req = 1'b0;
        if_req = 1'b0;
        chk("sim ls_edge", 32'(e_ls), 32'd2);
        chk("sim ls_rdata", r_ls, 32'h80);
        chk("sim if_edge", 32'(e_if), 32'd7);
        chk("sim if_inst", r_if, 32'h13);
        @(posedge clk); #1;

        // rdy low for three cycles mid-fetch
        if_req = 1'b1; if_addr = 32'h1000;
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk); #1;
        chk("frz mem_a_before", mem_a, 32'h1001);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("frz mem_a", mem_a, 32'h1001);
            chk("frz busy", 32'(busy), 32'd1);
        end
        rdy = 1'b1;
        lat = 4;
        got = 1'b0;
        while (!got && lat < 24) begin
            @(posedge clk); #1;
            lat++;
            if (if_success) got = 1'b1;
        end
        chk("frz latency", 32'(lat), 32'd7);
        chk("frz if_inst", if_inst, 32'h13);
        @(posedge clk); #1;

        // Reset in the middle of a word store
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2100; ls_size = 2'd3;
        ls_wdata = 32'h0102_0304;
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(posedge clk); #1;
        chk("rstmid mem_wr_before", 32'(mem_wr), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid mem_wr", 32'(mem_wr), 32'd0);
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid ls_done", 32'(ls_done), 32'd0);
        rst = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (ls_done || if_success || busy) got = 1'b1;
        end
        chk("rstmid quiet", 32'(got), 32'd0);
        run_xfer(1'b1, 1'b0, 32'h1000, 2'd3, 32'h0, 32'h13, "rstmid fetch");

        // Randomised traffic against the reference image
        for (int t = 0; t < 40; t++) begin
            kind  = int'($urandom_range(0, 2));
            fetch = (kind == 0);
            we    = (kind == 2);
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           addr = 32'h0000_0100 + 32'($urandom_range(0, 31));
            size  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            run_xfer(fetch, we, addr, size, wdata,
                     ref_read(addr, nbytes(fetch, size)), $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_ctrl
`default_nettype wire
